// File: rtl/keccak_sponge_arbiter.sv
// Round-robin session arbiter sharing one keccak_sponge among N_REQ requesters.
// A grant is locked for a whole hash session until release or watchdog revoke.
module keccak_sponge_arbiter #(
    parameter int         N_REQ    = 3,
    parameter int         IDW      = $clog2(N_REQ),
    parameter int         TIMEOUT  = 4096,
    parameter logic [4:0] DEF_RATE = 5'd21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [N_REQ-1:0]      rel_i,
    input  logic [5*N_REQ-1:0]    rate_i,
    input  logic [N_REQ-1:0]      absorb_valid_i,
    input  logic [64*N_REQ-1:0]   absorb_data_i,
    input  logic [N_REQ-1:0]      absorb_last_i,
    input  logic [N_REQ-1:0]      squeeze_ready_i,
    output logic [N_REQ-1:0]      grant_o,
    output logic [N_REQ-1:0]      absorb_ready_o,
    output logic [N_REQ-1:0]      squeeze_valid_o,
    output logic [63:0]           squeeze_data_o,
    output logic [4:0]            sp_rate_o,
    output logic                  sp_absorb_valid_o,
    output logic [63:0]           sp_absorb_data_o,
    output logic                  sp_absorb_last_o,
    output logic                  sp_squeeze_ready_o,
    input  logic                  sp_absorb_ready_i,
    input  logic                  sp_squeeze_valid_i,
    input  logic [63:0]           sp_squeeze_data_i,
    input  logic                  sp_busy_i,
    output logic [IDW-1:0]        owner_o,
    output logic                  active_o,
    output logic                  timeout_err_o,
    output logic [IDW-1:0]        timeout_id_o,
    input  logic                  err_clr_i
);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [IDW-1:0]   owner_n, rr_ptr, rr_ptr_n, winner;
    logic             win_found;
    logic [4:0]       rate_q, rate_n;
    logic             active_n;
    logic [WDW-1:0]   wd_cnt, wd_cnt_n;
    logic             err_n;
    logic [IDW-1:0]   err_id_n;
    logic             handshake, wd_expire;

    // Only the owner's slice reaches the sponge, and only while ACTIVE; DRAIN and
    // IDLE present an inert interface so no handshake can fire between sessions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        sp_absorb_valid_o  = 1'b0;
        sp_absorb_data_o   = '0;
        sp_absorb_last_o   = 1'b0;
        sp_squeeze_ready_o = 1'b0;
        absorb_ready_o     = '0;
        squeeze_valid_o    = '0;
        if (state == ACTIVE) begin
            sp_absorb_valid_o        = absorb_valid_i[owner_o];
            sp_absorb_data_o         = absorb_data_i[64*owner_o +: 64];
            sp_absorb_last_o         = absorb_last_i[owner_o];
            sp_squeeze_ready_o       = squeeze_ready_i[owner_o];
            absorb_ready_o[owner_o]  = sp_absorb_ready_i;
            squeeze_valid_o[owner_o] = sp_squeeze_valid_i;
        end
    end

    assign sp_rate_o      = (state == IDLE) ? DEF_RATE : rate_q;
    assign squeeze_data_o = sp_squeeze_data_i;

    // Round-robin search starting at rr_ptr with an explicit wrap at N_REQ.
    always_comb begin
        int cand;
        winner    = rr_ptr;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                winner    = IDW'(cand);
            end
        end
    end

    assign handshake = (sp_absorb_valid_o & sp_absorb_ready_i) |
                       (sp_squeeze_ready_o & sp_squeeze_valid_i);
    assign wd_expire = (state == ACTIVE) && !handshake && !sp_busy_i &&
                       (wd_cnt == WDW'(TIMEOUT - 1));

    always_comb begin
        state_n  = state;
        grant_n  = grant_o;
        owner_n  = owner_o;
        rr_ptr_n = rr_ptr;
        rate_n   = rate_q;
        active_n = active_o;
        wd_cnt_n = wd_cnt;
        err_n    = timeout_err_o;
        err_id_n = timeout_id_o;
        if (err_clr_i) err_n = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && !sp_busy_i) begin
                    state_n          = ACTIVE;
                    grant_n          = '0;
                    grant_n[winner]  = 1'b1;
                    owner_n          = winner;
                    rate_n           = rate_i[5*winner +: 5];
                    active_n         = 1'b1;
                    wd_cnt_n         = '0;
                end
            end
            ACTIVE: begin
                if (handshake || sp_busy_i) wd_cnt_n = '0;
                else if (wd_cnt != '1)      wd_cnt_n = wd_cnt + 1'b1;
                if (rel_i[owner_o] || wd_expire) begin
                    state_n  = DRAIN;
                    grant_n  = '0;
                    rr_ptr_n = (owner_o == IDW'(N_REQ - 1)) ? '0 : owner_o + 1'b1;
                end
                // A new timeout overrides a simultaneous err_clr_i.
                if (wd_expire) begin
                    err_n    = 1'b1;
                    err_id_n = owner_o;
                end
            end
            DRAIN: begin
                if (!sp_busy_i) begin
                    state_n  = IDLE;
                    active_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_o       <= '0;
            owner_o       <= '0;
            rr_ptr        <= '0;
            rate_q        <= DEF_RATE;
            active_o      <= 1'b0;
            wd_cnt        <= '0;
            timeout_err_o <= 1'b0;
            timeout_id_o  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= state_n;
            grant_o       <= grant_n;
            owner_o       <= owner_n;
            rr_ptr        <= rr_ptr_n;
            rate_q        <= rate_n;
            active_o      <= active_n;
            wd_cnt        <= wd_cnt_n;
            timeout_err_o <= err_n;
            timeout_id_o  <= err_id_n;
        end
    end
endmodule

// File: tb/tb_keccak_sponge_arbiter.sv
// Scoreboard bench for keccak_sponge_arbiter: requester-side handshakes are queued
// with the session rate, and a monitor checks them on the sponge side.
module tb_keccak_sponge_arbiter;
    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_i, rel_i, absorb_valid_i, absorb_last_i, squeeze_ready_i;
    logic [5*N-1:0]    rate_i;
    logic [64*N-1:0]   absorb_data_i;
    logic [N-1:0]      grant_o, absorb_ready_o, squeeze_valid_o;
    logic [63:0]       squeeze_data_o, sp_absorb_data_o, sp_squeeze_data_i;
    logic [4:0]        sp_rate_o;
    logic              sp_absorb_valid_o, sp_absorb_last_o, sp_squeeze_ready_o;
    logic              sp_absorb_ready_i, sp_squeeze_valid_i, sp_busy_i;
    logic [IDW-1:0]    owner_o, timeout_id_o;
    logic              active_o, timeout_err_o, err_clr_i;

    keccak_sponge_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .rel_i(rel_i), .rate_i(rate_i),
        .absorb_valid_i(absorb_valid_i), .absorb_data_i(absorb_data_i),
        .absorb_last_i(absorb_last_i), .squeeze_ready_i(squeeze_ready_i),
        .grant_o(grant_o), .absorb_ready_o(absorb_ready_o),
        .squeeze_valid_o(squeeze_valid_o), .squeeze_data_o(squeeze_data_o),
        .sp_rate_o(sp_rate_o), .sp_absorb_valid_o(sp_absorb_valid_o),
        .sp_absorb_data_o(sp_absorb_data_o), .sp_absorb_last_o(sp_absorb_last_o),
        .sp_squeeze_ready_o(sp_squeeze_ready_o), .sp_absorb_ready_i(sp_absorb_ready_i),
        .sp_squeeze_valid_i(sp_squeeze_valid_i), .sp_squeeze_data_i(sp_squeeze_data_i),
        .sp_busy_i(sp_busy_i), .owner_o(owner_o), .active_o(active_o),
        .timeout_err_o(timeout_err_o), .timeout_id_o(timeout_id_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sqz;
        logic [63:0] data;
        bit          last;
        logic [4:0]  rate;
        int          owner;
    } hs_t;

    hs_t        exp_q[$];
    int         exp_grant[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rel_cyc = 0;
    int         model_ptr = 0;
    logic [4:0] model_rate = 5'd21;
    bit         sponge_rand = 1'b1;
    logic [N-1:0] prev_grant = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference round-robin choice: first requester at or after the pointer.
    function automatic int pick(input logic [N-1:0] req);
        for (int i = 0; i < N; i++)
            if (req[(model_ptr + i) % N]) return (model_ptr + i) % N;
        return -1;
    endfunction

    // Sponge model: random ready/valid/data, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sponge_rand) begin
                sp_absorb_ready_i  = 1'($urandom_range(0, 1));
                sp_squeeze_valid_i = 1'($urandom_range(0, 1));
                sp_squeeze_data_i  = {$urandom, $urandom};
            end
        end
    end

    task automatic monitor_cycle();
        hs_t          e;
        logic [N-1:0] oh;
        logic [63:0]  exp_data = '0;
        logic         exp_v = 1'b0, exp_l = 1'b0, exp_sr = 1'b0;
        for (int k = 0; k < N; k++)
            if (grant_o[k]) begin
                exp_data = absorb_data_i[k*64 +: 64];
                exp_v    = absorb_valid_i[k];
                exp_l    = absorb_last_i[k];
                exp_sr   = squeeze_ready_i[k];
            end
        check("grant_onehot", $onehot0(grant_o), 1);
        check("sp_absorb_valid", sp_absorb_valid_o, exp_v);
        check("sp_absorb_last", sp_absorb_last_o, exp_l);
        check("sp_squeeze_ready", sp_squeeze_ready_o, exp_sr);
        if (grant_o != '0) check("sp_absorb_data", sp_absorb_data_o, exp_data);
        check("absorb_ready_gate", absorb_ready_o, sp_absorb_ready_i ? grant_o : '0);
        check("squeeze_valid_gate", squeeze_valid_o, sp_squeeze_valid_i ? grant_o : '0);
        check("squeeze_data_bcast", squeeze_data_o, sp_squeeze_data_i);
        if (prev_grant == '0 && grant_o != '0) begin
            if (exp_grant.size() == 0) check("unexpected_grant", grant_o, 0);
            else begin
                int g = exp_grant.pop_front();
                oh = '0;
                oh[g] = 1'b1;
                check("grant_order", grant_o, oh);
                check("owner_at_grant", owner_o, g);
                check("active_at_grant", active_o, 1);
            end
        end
        if (sp_absorb_valid_o && sp_absorb_ready_i) begin
            if (exp_q.size() == 0) check("unexpected_absorb_hs", 1, 0);
            else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.owner] = 1'b1;
                check("hs_kind_absorb", e.sqz, 0);
                check("absorb_data", sp_absorb_data_o, e.data);
                check("absorb_last", sp_absorb_last_o, e.last);
                check("absorb_rate", sp_rate_o, e.rate);
                check("absorb_owner", grant_o, oh);
            end
        end
        if (sp_squeeze_ready_o && sp_squeeze_valid_i) begin
            if (exp_q.size() == 0) check("unexpected_squeeze_hs", 1, 0);
            else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.owner] = 1'b1;
                check("hs_kind_squeeze", e.sqz, 1);
                check("squeeze_data", squeeze_data_o, e.data);
                check("squeeze_rate", sp_rate_o, e.rate);
                check("squeeze_valid_owner", squeeze_valid_o, oh);
            end
        end
    endtask

    // Monitor samples one time unit before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) monitor_cycle();
            prev_grant = grant_o;
        end
    end

    task automatic wait_grant(output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (grant_o != '0) got = 1'b1;
        end
        check("grant_within_budget", got, 1);
    endtask

    task automatic start_session(input logic [N-1:0] req, output int who, output int lat);
        who = pick(req);
        exp_grant.push_back(who);
        req_i = req;
        wait_grant(lat);
        model_rate = rate_i[5*who +: 5];
    endtask

    task automatic end_session(input int k);
        rel_i[k] = 1'b1;
        rel_cyc = cyc;
        @(negedge clk);
        rel_i[k] = 1'b0;
        model_ptr = (k + 1) % N;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            if (!active_o) idle = 1'b1;
        end
        check("idle_within_budget", idle, 1);
    endtask

    task automatic do_absorb(input int k, input logic [63:0] d, input bit l);
        bit done = 1'b0;
        absorb_valid_i[k]         = 1'b1;
        absorb_data_i[k*64 +: 64] = d;
        absorb_last_i[k]          = l;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (absorb_ready_o[k]) begin
                exp_q.push_back('{1'b0, d, l, model_rate, k});
                done = 1'b1;
            end
            @(negedge clk);
        end
        absorb_valid_i[k] = 1'b0;
        absorb_last_i[k]  = 1'b0;
        check("absorb_done", done, 1);
    endtask

    task automatic do_squeeze(input int k);
        bit done = 1'b0;
        squeeze_ready_i[k] = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (squeeze_valid_o[k]) begin
                exp_q.push_back('{1'b1, sp_squeeze_data_i, 1'b0, model_rate, k});
                done = 1'b1;
            end
            @(negedge clk);
        end
        squeeze_ready_i[k] = 1'b0;
        check("squeeze_done", done, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", grant_o, 0);
        check("rst_owner", owner_o, 0);
        check("rst_active", active_o, 0);
        check("rst_err", timeout_err_o, 0);
        check("rst_err_id", timeout_id_o, 0);
        check("rst_rate", sp_rate_o, 21);
        check("rst_sp_absorb_valid", sp_absorb_valid_o, 0);
        check("rst_sp_absorb_data", sp_absorb_data_o, 0);
        check("rst_sp_absorb_last", sp_absorb_last_o, 0);
        check("rst_sp_squeeze_ready", sp_squeeze_ready_o, 0);
        check("rst_absorb_ready", absorb_ready_o, 0);
        check("rst_squeeze_valid", squeeze_valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w, lat, n;
        req_i = '0; rel_i = '0; rate_i = '0; absorb_valid_i = '0; absorb_data_i = '0;
        absorb_last_i = '0; squeeze_ready_i = '0; err_clr_i = 1'b0;
        sp_absorb_ready_i = 1'b1; sp_squeeze_valid_i = 1'b0; sp_squeeze_data_i = '0;
        sp_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Single session: two absorbs then one squeeze, release held up by sp_busy_i.
        rate_i[4:0] = 5'($urandom_range(1, 31));
        start_session(3'b001, w, lat);
        check("req_to_grant_latency", lat, 1);
        do_absorb(0, {$urandom, $urandom}, 1'b0);
        do_absorb(0, {$urandom, $urandom}, 1'b1);
        do_squeeze(0);
        req_i = '0;
        sp_busy_i = 1'b1;
        end_session(0);
        check("drain_grant", grant_o, 0);
        check("drain_active", active_o, 1);
        check("drain_rate", sp_rate_o, model_rate);
        repeat (3) @(negedge clk);
        check("drain_active_busy", active_o, 1);
        sp_busy_i = 1'b0;
        wait_idle();
        check("idle_rate", sp_rate_o, 21);

        // All requesting: round-robin order, one handshake each, fixed regrant gap.
        rate_i = 15'($urandom);
        for (int r = 0; r < 4; r++) begin
            start_session(3'b111, w, lat);
            // rel edge -> DRAIN, next edge -> IDLE, next edge -> grant.
            if (r > 0) check("regrant_gap", cyc - rel_cyc, 3);
            if ($urandom_range(0, 1) != 0) do_absorb(w, {$urandom, $urandom}, 1'b1);
            else do_squeeze(w);
            if (r == 3) req_i = '0;
            end_session(w);
        end
        wait_idle();

        // Owner 1 active while requester 2 drives its own absorb and squeeze.
        rate_i[9:5] = 5'($urandom_range(1, 31));
        start_session(3'b010, w, lat);
        absorb_valid_i[2] = 1'b1;
        absorb_data_i[128 +: 64] = 64'hdead_beef_0bad_f00d;
        absorb_last_i[2] = 1'b1;
        squeeze_ready_i[2] = 1'b1;
        for (int i = 0; i < 3; i++) do_absorb(1, {$urandom, $urandom}, i == 2);
        absorb_valid_i[2] = 1'b0;
        absorb_last_i[2] = 1'b0;
        squeeze_ready_i[2] = 1'b0;
        req_i = '0;
        end_session(1);
        wait_idle();

        // Rate latched at grant; later change to rate_i is ignored.
        rate_i[4:0] = 5'd17;
        start_session(3'b001, w, lat);
        rate_i[4:0] = 5'd9;
        do_absorb(0, {$urandom, $urandom}, 1'b1);
        check("latched_rate", sp_rate_o, 17);
        req_i = '0;
        end_session(0);
        check("drain_latched_rate", sp_rate_o, 17);
        wait_idle();
        check("rate_back_to_default", sp_rate_o, 21);

        // Watchdog: owner 2 never handshakes.
        start_session(3'b100, w, lat);
        check("timeout_session_owner", w, 2);
        check("timeout_req_latency", lat, 1);
        req_i = '0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant_o[2]) n++;
            else break;
        end
        check("watchdog_cycles", n, TO);
        check("timeout_err_set", timeout_err_o, 1);
        check("timeout_id", timeout_id_o, 2);
        check("timeout_drain_active", active_o, 1);
        model_ptr = 0;
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_cleared", timeout_err_o, 0);
        check("err_id_kept", timeout_id_o, 2);
        wait_idle();

        // Reset in the middle of a squeeze, then a fresh grant.
        sponge_rand = 1'b0;
        sp_absorb_ready_i = 1'b1;
        sp_squeeze_valid_i = 1'b0;
        rate_i = 15'($urandom);
        start_session(3'b111, w, lat);
        check("ptr_after_timeout", w, 0);
        req_i = '0;
        do_absorb(0, {$urandom, $urandom}, 1'b1);
        squeeze_ready_i[0] = 1'b1;
        @(negedge clk);
        check("mid_squeeze_ready", sp_squeeze_ready_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        check("queue_empty_at_reset", exp_q.size(), 0);
        squeeze_ready_i[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        sponge_rand = 1'b1;
        start_session(3'b100, w, lat);
        check("post_reset_latency", lat, 1);
        req_i = '0;
        do_squeeze(2);
        end_session(2);
        wait_idle();

        repeat (2) @(negedge clk);
        check("hs_queue_drained", exp_q.size(), 0);
        check("grant_queue_drained", exp_grant.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
